// File: rtl/frame_buffer_arbiter.sv
// Camera-to-SRAM-to-VGA frame buffer controller: buffers camera pixels in a small FIFO,
// arbitrates one single-port SRAM (VGA reads first) and ping-pongs two frame banks.
module frame_buffer_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 20,
    parameter int PIX_W        = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clock_200mhz,
    input  logic              pin_reset,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    input  logic [PIX_W-1:0]  cam_addr,
    input  logic              cam_frame_done,
    output logic              cam_ready,
    input  logic              vga_req,
    input  logic [PIX_W-1:0]  vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_data_valid,
    output logic [ADDR_W-1:0] sram_address,
    output logic [1:0]        sram_byteenable,
    output logic              sram_read,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    input  logic [DATA_W-1:0] sram_readdata,
    input  logic              sram_readdatavalid,
    output logic              wr_bank,
    output logic              disp_bank,
    output logic [7:0]        frames_captured,
    output logic              overflow,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [1:0]        mode_q;
    logic              stop_pending;
    logic              arm, push, drop, swap, pop;

    logic [PIX_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty;
    logic [7:0]        rd_inflight;
    logic              rd_vld_p1;

    function automatic logic [ADDR_W-1:0] bank_base(input logic b);
        bank_base = b ? ADDR_W'(FRAME_PIXELS) : '0;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !vga_req && !fifo_empty;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cam_ready = 1'b0;
        arm       = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (mode == 2'b01 || mode == 2'b10)) begin
                    arm       = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (cam_frame_done) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cam_ready = !fifo_full;
                push      = cam_valid && !fifo_full;
                drop      = cam_valid && fifo_full;
                if (cam_frame_done) state_nxt = FLUSH;
            end
            FLUSH: begin
                // An empty FIFO here means its last write has already been registered out.
                if (fifo_empty) begin
                    swap      = 1'b1;
                    state_nxt = (mode_q == 2'b01 || stop_pending || stop) ? IDLE : CAPTURE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_200mhz or negedge pin_reset) begin
        if (!pin_reset) begin
            state           <= IDLE;
            mode_q          <= 2'b00;
            stop_pending    <= 1'b0;
            overflow        <= 1'b0;
            wr_bank         <= 1'b0;
            disp_bank       <= 1'b1;
            frames_captured <= 8'd0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                mode_q       <= mode;
                overflow     <= 1'b0;
                stop_pending <= 1'b0;
            end else begin
                if (state != IDLE && stop) stop_pending <= 1'b1;
                if (drop) overflow <= 1'b1;
            end
            if (swap) begin
                disp_bank       <= wr_bank;
                wr_bank         <= ~wr_bank;
                frames_captured <= frames_captured + 8'd1;
            end
        end
    end

    // Stage p0: write FIFO
    always_ff @(posedge clock_200mhz or negedge pin_reset) begin
        if (!pin_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock_200mhz) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= cam_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= cam_data;
        end
    end

    // Stage p1: registered SRAM command
    always_ff @(posedge clock_200mhz or negedge pin_reset) begin
        if (!pin_reset) begin
            sram_read       <= 1'b0;
            sram_write      <= 1'b0;
            sram_byteenable <= 2'b00;
            sram_address    <= '0;
            sram_writedata  <= '0;
        end else begin
            sram_read       <= vga_req;
            sram_write      <= pop;
            sram_byteenable <= (vga_req || pop) ? 2'b11 : 2'b00;
            if (vga_req) begin
                sram_address <= ADDR_W'(vga_addr) + bank_base(disp_bank);
            end else if (pop) begin
                sram_address   <= ADDR_W'(fifo_addr[rd_ptr[PTR_W-1:0]]) + bank_base(wr_bank);
                sram_writedata <= fifo_data[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // Stage p2: read return; returns for reads issued before a reset are not counted and are dropped
    assign rd_vld_p1 = sram_readdatavalid && (rd_inflight != 8'd0);

    always_ff @(posedge clock_200mhz or negedge pin_reset) begin
        if (!pin_reset) begin
            rd_inflight    <= 8'd0;
            vga_data_valid <= 1'b0;
            vga_data       <= '0;
        end else begin
            rd_inflight    <= rd_inflight + {7'd0, sram_read} - {7'd0, rd_vld_p1};
            vga_data_valid <= rd_vld_p1;
            if (rd_vld_p1) vga_data <= sram_readdata;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Randomized bench for frame_buffer_arbiter with a queue-based reference model and a
// fixed-latency SRAM model; FRAME_PIXELS is shrunk to 16 so frames stay short.
module tb_frame_buffer_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int PIX_W  = 5;
    localparam int FP     = 16;
    localparam int DEPTH  = 16;

    localparam int M_IDLE = 0, M_ARM = 1, M_CAP = 2, M_FLUSH = 3;

    logic              clk = 1'b0;
    logic              pin_reset = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              start = 1'b0, stop = 1'b0;
    logic              cam_valid = 1'b0, cam_frame_done = 1'b0;
    logic [DATA_W-1:0] cam_data = '0;
    logic [PIX_W-1:0]  cam_addr = '0;
    logic              cam_ready;
    logic              vga_req = 1'b0;
    logic [PIX_W-1:0]  vga_addr = '0;
    logic [DATA_W-1:0] vga_data;
    logic              vga_data_valid;
    logic [ADDR_W-1:0] sram_address;
    logic [1:0]        sram_byteenable;
    logic              sram_read, sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic [DATA_W-1:0] sram_readdata = '0;
    logic              sram_readdatavalid = 1'b0;
    logic              wr_bank, disp_bank, overflow, busy;
    logic [7:0]        frames_captured;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 0;
    bit rnd_rd_en = 0;
    int wr_cnt = 0;

    frame_buffer_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock_200mhz(clk), .pin_reset(pin_reset), .mode(mode), .start(start), .stop(stop),
        .cam_valid(cam_valid), .cam_data(cam_data), .cam_addr(cam_addr),
        .cam_frame_done(cam_frame_done), .cam_ready(cam_ready),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_data_valid(vga_data_valid),
        .sram_address(sram_address), .sram_byteenable(sram_byteenable),
        .sram_read(sram_read), .sram_write(sram_write), .sram_writedata(sram_writedata),
        .sram_readdata(sram_readdata), .sram_readdatavalid(sram_readdatavalid),
        .wr_bank(wr_bank), .disp_bank(disp_bank), .frames_captured(frames_captured),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // SRAM model: two-cycle read latency, in-order returns
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] ref_mem [256];
    logic              rv1 = 1'b0;
    logic [DATA_W-1:0] rd1 = '0;

    always @(posedge clk) begin
        if (sram_write) mem[sram_address] <= sram_writedata;
        rv1                <= sram_read;
        rd1                <= mem[sram_address];
        sram_readdatavalid <= rv1;
        sram_readdata      <= rd1;
    end

    always @(negedge clk) if (pin_reset && sram_write) wr_cnt++;

    // Reference model: frame-level rules on a pixel queue, evaluated once per clock
    int                m_st = M_IDLE;
    logic [PIX_W-1:0]  mq_a [$];
    logic [DATA_W-1:0] mq_d [$];
    bit                m_wr = 0, m_disp = 1, m_ovf = 0, m_stop = 0, m_full, m_empty;
    logic [1:0]        m_mode = 2'b00;
    logic [7:0]        m_frames = 8'd0;
    bit                e_rd = 0, e_wr = 0, e_vv = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wd = '0, e_vd = '0;
    bit                rq_v [3];
    logic [DATA_W-1:0] rq_d [3];

    function automatic logic [ADDR_W-1:0] fb(input bit b);
        return b ? ADDR_W'(FP) : '0;
    endfunction

    always @(posedge clk) begin
        if (!pin_reset) begin
            m_st = M_IDLE; mq_a.delete(); mq_d.delete();
            m_wr = 0; m_disp = 1; m_ovf = 0; m_stop = 0; m_mode = 2'b00; m_frames = 8'd0;
            e_rd = 0; e_wr = 0; e_vv = 0; e_vd = '0;
            for (int i = 0; i < 3; i++) begin rq_v[i] = 0; rq_d[i] = '0; end
        end else begin
            m_full  = (mq_a.size() == DEPTH);
            m_empty = (mq_a.size() == 0);
            e_rd = 0;
            e_wr = 0;
            if (vga_req) begin
                e_rd   = 1;
                e_addr = ADDR_W'(vga_addr) + fb(m_disp);
            end else if (!m_empty) begin
                e_wr   = 1;
                e_addr = ADDR_W'(mq_a.pop_front()) + fb(m_wr);
                e_wd   = mq_d.pop_front();
                ref_mem[e_addr] = e_wd;
            end
            e_vv = rq_v[2];
            if (rq_v[2]) e_vd = rq_d[2];
            rq_v[2] = rq_v[1]; rq_d[2] = rq_d[1];
            rq_v[1] = rq_v[0]; rq_d[1] = rq_d[0];
            rq_v[0] = e_rd;    rq_d[0] = e_rd ? ref_mem[e_addr] : '0;
            if (m_st != M_IDLE && stop) m_stop = 1;
            case (m_st)
                M_IDLE: if (start && (mode == 2'b01 || mode == 2'b10)) begin
                    m_mode = mode; m_ovf = 0; m_stop = 0; m_st = M_ARM;
                end
                M_ARM: if (cam_frame_done) m_st = M_CAP;
                M_CAP: begin
                    if (cam_valid) begin
                        if (m_full) m_ovf = 1;
                        else begin mq_a.push_back(cam_addr); mq_d.push_back(cam_data); end
                    end
                    if (cam_frame_done) m_st = M_FLUSH;
                end
                default: if (m_empty) begin
                    m_disp = m_wr; m_wr = !m_wr; m_frames = m_frames + 8'd1;
                    m_st = (m_mode == 2'b01 || m_stop) ? M_IDLE : M_CAP;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (pin_reset && chk_on) begin
            chk("sram_read", 32'(sram_read), 32'(e_rd));
            chk("sram_write", 32'(sram_write), 32'(e_wr));
            chk("sram_byteenable", 32'(sram_byteenable), (e_rd || e_wr) ? 32'd3 : 32'd0);
            if (e_rd || e_wr) chk("sram_address", 32'(sram_address), 32'(e_addr));
            if (e_wr) chk("sram_writedata", 32'(sram_writedata), 32'(e_wd));
            chk("wr_bank", 32'(wr_bank), 32'(m_wr));
            chk("disp_bank", 32'(disp_bank), 32'(m_disp));
            chk("frames_captured", 32'(frames_captured), 32'(m_frames));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("busy", 32'(busy), 32'(m_st != M_IDLE));
            chk("cam_ready", 32'(cam_ready), 32'(m_st == M_CAP && mq_a.size() < DEPTH));
            chk("vga_data_valid", 32'(vga_data_valid), 32'(e_vv));
            if (e_vv) chk("vga_data", 32'(vga_data), 32'(e_vd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start = 0; stop = 0; cam_valid = 0; cam_frame_done = 0; vga_req = 0;
        if (rnd_rd_en && $urandom_range(0, 9) < 3) begin
            vga_req  = 1;
            vga_addr = PIX_W'($urandom_range(0, FP - 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        pin_reset = 0;
        start = 0; stop = 0; cam_valid = 0; cam_frame_done = 0; vga_req = 0;
        repeat (3) @(posedge clk);
        #1;
        pin_reset = 1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300 && busy; k++) step();
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_frames(input logic [7:0] target);
        for (int k = 0; k < 300 && frames_captured != target; k++) step();
        chk("wait_frames", 32'(frames_captured), 32'(target));
    endtask

    task automatic send_pixel(input int a, input logic [DATA_W-1:0] d);
        step();
        cam_valid = 1;
        cam_addr  = PIX_W'(a);
        cam_data  = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        bit b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DATA_W'(16'h5000 + i);
            ref_mem[i] = DATA_W'(16'h5000 + i);
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_read", 32'(sram_read), 0);
        chk("rst_sram_write", 32'(sram_write), 0);
        chk("rst_sram_address", 32'(sram_address), 0);
        chk("rst_sram_be", 32'(sram_byteenable), 0);
        chk("rst_sram_wdata", 32'(sram_writedata), 0);
        chk("rst_wr_bank", 32'(wr_bank), 0);
        chk("rst_disp_bank", 32'(disp_bank), 1);
        chk("rst_frames", 32'(frames_captured), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cam_ready", 32'(cam_ready), 0);
        chk("rst_vga_valid", 32'(vga_data_valid), 0);
        chk("rst_vga_data", 32'(vga_data), 0);
        @(posedge clk);
        #1;
        pin_reset = 1;
        chk_on    = 1;

        // Read from display bank 1 in IDLE
        step();
        vga_req  = 1;
        vga_addr = 5;
        step();
        @(negedge clk);
        chk("t1_sram_read", 32'(sram_read), 1);
        chk("t1_sram_address", 32'(sram_address), 21);
        for (int k = 0; k < 10 && !sram_readdatavalid; k++) @(negedge clk);
        chk("t1_readdatavalid", 32'(sram_readdatavalid), 1);
        @(negedge clk);
        chk("t1_vga_valid", 32'(vga_data_valid), 1);
        chk("t1_vga_data", 32'(vga_data), 32'h5015);

        // Single-shot frame with random read traffic
        rnd_rd_en = 1;
        step(); start = 1; mode = 2'b01;
        step(); cam_frame_done = 1;
        for (int i = 0; i < FP; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send_pixel(i, DATA_W'(16'hA000 + i));
        end
        step(); cam_frame_done = 1;
        wait_idle("t2_idle");
        chk("t2_disp_bank", 32'(disp_bank), 0);
        chk("t2_wr_bank", 32'(wr_bank), 1);
        chk("t2_frames", 32'(frames_captured), 1);
        for (int i = 0; i < FP; i++) chk("t2_mem", 32'(mem[i]), 32'(16'hA000 + i));

        // Continuous capture; pixels in ARM are ignored; stop during frame 4
        rnd_rd_en = 0;
        do_reset();
        step(); start = 1; mode = 2'b10;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            send_pixel(i, DATA_W'($urandom));
            chk("t3_arm_ready", 32'(cam_ready), 0);
        end
        step();
        chk("t3_arm_writes", 32'(wr_cnt - w0), 0);
        rnd_rd_en = 1;
        cam_frame_done = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FP; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                send_pixel(i, DATA_W'($urandom));
                if (f == 3 && i == 8) stop = 1;
            end
            step(); cam_frame_done = 1;
            wait_frames(8'(f + 1));
            chk("t4_disp_alt", 32'(disp_bank), 32'(f % 2));
        end
        wait_idle("t4_idle");
        chk("t4_frames", 32'(frames_captured), 4);

        // FIFO overflow while reads starve writes
        rnd_rd_en = 0;
        step(); start = 1; mode = 2'b01;
        step(); cam_frame_done = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            vga_req  = 1;
            vga_addr = PIX_W'($urandom_range(0, FP - 1));
            if (c < 20) begin
                cam_valid = 1;
                cam_addr  = PIX_W'(c % FP);
                cam_data  = DATA_W'(16'hB000 + c);
            end
            if (c >= 16 && c < 20) chk("t5_ready_full", 32'(cam_ready), 0);
        end
        w0 = wr_cnt;
        repeat (30) step();
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_drain_count", 32'(wr_cnt - w0), 16);
        step(); cam_frame_done = 1;
        wait_idle("t5_idle");

        // Last pixel coincident with the frame boundary
        b0 = wr_bank;
        step(); start = 1; mode = 2'b01;
        step(); cam_frame_done = 1;
        for (int i = 0; i < FP - 1; i++) send_pixel(i, DATA_W'(16'hC000 + i));
        send_pixel(FP - 1, 16'hC00F);
        cam_frame_done = 1;
        wait_idle("t6_idle");
        chk("t6_last_pixel", 32'(mem[fb(b0) + ADDR_W'(FP - 1)]), 32'h0000C00F);
        chk("t6_disp_bank", 32'(disp_bank), 32'(b0));

        // Reset while FLUSH is stalled behind continuous reads
        step(); start = 1; mode = 2'b01;
        step(); cam_frame_done = 1;
        for (int i = 0; i < 4; i++) begin
            send_pixel(i, DATA_W'($urandom));
            vga_req = 1;
        end
        step(); cam_frame_done = 1; vga_req = 1;
        step(); vga_req = 1;
        chk("t6_in_flush", 32'(busy), 1);
        do_reset();
        w0 = wr_cnt;
        repeat (20) step();
        chk("t6_rst_writes", 32'(wr_cnt - w0), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_frames", 32'(frames_captured), 0);
        chk("t6_rst_wr_bank", 32'(wr_bank), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
Parametrised camera-to-SRAM-to-VGA frame buffer controller that shares one single-port Avalon-style SRAM between a camera pixel write stream and a VGA pixel read stream.
- Camera pixels are buffered in a write FIFO; SRAM accesses are arbitrated per cycle, with VGA reads taking priority.
- Ping-pong double buffering means the display never reads the frame being written.
- Single-shot or continuous capture is selectable, and capture is aligned to frame boundaries.
- Sits between camera_read/VGA_Ctrl and the sram core; runs entirely in the 200 MHz domain.

Parameters:
DATA_W, 16, pixel/SRAM data width (RGB565)
ADDR_W, 20, SRAM word address width
PIX_W, 19, pixel index width
FRAME_PIXELS, 307200, pixels per frame; bank1 base address = FRAME_PIXELS; legality requires 2*FRAME_PIXELS <= 2**ADDR_W
FIFO_DEPTH, 16, write FIFO entries; power of two, >= 2

Ports:
clock_200mhz  in  1  sole clock, rising edge
pin_reset  in  1  asynchronous, active-low reset
mode  in  2  01 = single-shot, 10 = continuous, 00/11 = ignore start; sampled only when start is accepted
start  in  1  one-cycle pulse: arm capture (accepted only in IDLE)
stop  in  1  one-cycle pulse: in continuous mode, finish current frame then return to IDLE
cam_valid  in  1  pixel strobe
cam_data  in  DATA_W  pixel value
cam_addr  in  PIX_W  pixel index within the frame
cam_frame_done  in  1  one-cycle pulse: frame boundary (vsync)
cam_ready  out  1  high when a pixel will be accepted
vga_req  in  1  one-cycle read request; may be asserted every cycle
vga_addr  in  PIX_W  pixel index to read
vga_data  out  DATA_W  returned pixel
vga_data_valid  out  1  vga_data strobe
sram_address  out  ADDR_W
sram_byteenable  out  2
sram_read  out  1
sram_write  out  1
sram_writedata  out  DATA_W
sram_readdata  in  DATA_W
sram_readdatavalid  in  1  SRAM returns reads in order, fixed latency >= 1
wr_bank  out  1  bank currently being written
disp_bank  out  1  bank currently being displayed
frames_captured  out  8  completed frames, wraps 255 -> 0
overflow  out  1  sticky: pixel dropped because FIFO was full
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE; FIFO empty.
  - wr_bank = 0, disp_bank = 1.
  - frames_captured = 0, overflow = 0, busy = 0, cam_ready = 0.
  - vga_data = 0, vga_data_valid = 0.
  - All sram_* outputs = 0.
  - Reset mid-operation discards FIFO contents and any in-flight reads; no vga_data_valid is produced after reset.
- State machine (IDLE, ARM, CAPTURE, FLUSH):
  - IDLE: start with mode 01/10 → ARM. On that transition, latch mode, clear overflow and stop_pending.
  - ARM: cam_ready = 0. cam_frame_done → CAPTURE, which drops the partial frame in progress.
  - CAPTURE: cam_ready = !fifo_full. A pixel is pushed when cam_valid && cam_ready.
    - cam_valid && fifo_full → pixel dropped, overflow <= 1.
    - cam_frame_done → FLUSH.
    - cam_valid in the same cycle as cam_frame_done is accepted as the last pixel of the ending frame.
  - FLUSH: cam_ready = 0. Once the FIFO is empty and its last write has been issued:
    - disp_bank <= wr_bank, wr_bank <= ~wr_bank, frames_captured += 1.
    - Then → IDLE if single-shot or stop_pending; otherwise → CAPTURE. The boundary pulse that ended the frame starts the next frame.
- stop is recorded as stop_pending in any non-IDLE state. In single-shot mode it has no extra effect.
- Arbitration: at most one SRAM command per cycle, and all sram_* outputs are registered.
  - Priority 1: vga_req in cycle t → sram_read = 1 in cycle t+1, sram_address = vga_addr + base(disp_bank).
  - Priority 2: otherwise, if the FIFO is non-empty → pop, sram_write = 1, sram_address = cam_addr + base(wr_bank), sram_writedata = cam_data.
  - base(b) = b ? FRAME_PIXELS : 0, zero-extended to ADDR_W.
  - sram_byteenable = 2'b11 on any command, else 2'b00.
  - Writes are starved while vga_req is held continuously. The FIFO absorbs this; excess pixels raise overflow.
- Reads: any number may be in flight.
  - vga_data/vga_data_valid are registered from sram_readdata/sram_readdatavalid, one cycle later, in request order.
  - A bank swap while reads are in flight does not affect them, because the address is fixed at issue.
  - Reads are served in every state, including IDLE.
- The FIFO is not written in IDLE, ARM or FLUSH. start in non-IDLE states is ignored.

Test Plan:
1. Reset released, FRAME_PIXELS = 16: all outputs 0 except disp_bank = 1; vga_req with vga_addr = 5 → sram_read with sram_address = 21 one cycle later, vga_data_valid one cycle after sram_readdatavalid.
2. Single-shot: start (mode = 01), cam_frame_done, 16 pixels addr 0..15 data 0xA000+i, cam_frame_done → writes to addresses 0..15 with matching data, then disp_bank = 0, wr_bank = 1, frames_captured = 1, state IDLE, busy = 0.
3. Pixels sent before the first cam_frame_done in ARM → no sram_write issued, cam_ready = 0.
4. Continuous mode for 3 frames → write bases alternate 0, 16, 0; disp_bank alternates 0, 1, 0; frames_captured = 3. stop pulse mid-frame 4 → frame 4 completes, then IDLE with frames_captured = 4.
5. vga_req held high for 40 cycles during CAPTURE with FIFO_DEPTH = 16 and 20 pixels sent → 16 accepted, overflow = 1, cam_ready = 0 while full; after vga_req drops, 16 writes drain in order.
6. cam_valid coincident with cam_frame_done → that pixel is written to the old bank before the swap; pin_reset asserted in FLUSH → IDLE, FIFO empty, no further sram_write.
